// File: rtl/imem_host_loader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : imem_host_loader
// Purpose  : Host-side writer for the CPU's external instruction-memory port.
//            Takes a valid/ready stream of 32-bit instruction words, writes
//            them to consecutive word addresses starting at BASE_ADDR, then
//            raises cpu_enable. With IMEM_HOST_LOADER_VERIFY_EN defined, the
//            loaded image is read back and checksummed before the CPU runs.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk, arst_n        clock, asynchronous active-low reset
//   start, word_count  begin a load of word_count words (sampled in IDLE)
//   halt               level; drop cpu_enable and return to IDLE
//   s_valid/s_data/s_ready   instruction word stream
//   addr_ext/wen_ext/ren_ext/wdata_ext/rdata_ext   memory external port
//   cpu_enable, busy, done, error   status
// Build option
//   IMEM_HOST_LOADER_VERIFY_EN : enables readback verify (VERIFY/VWAIT)
// ============================================================================
module imem_host_loader #(
  parameter int          ADDR_W    = 9,
  parameter logic [63:0] BASE_ADDR = 64'h0
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic              start,
  input  logic [ADDR_W:0]   word_count,
  input  logic              halt,
  input  logic              s_valid,
  input  logic [31:0]       s_data,
  output logic              s_ready,
  output logic [63:0]       addr_ext,
  output logic              wen_ext,
  output logic              ren_ext,
  output logic [31:0]       wdata_ext,
  input  logic [31:0]       rdata_ext,
  output logic              cpu_enable,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam logic [ADDR_W:0] ONE_WORD = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [63:0]     WORD_BYTES = 64'd4;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_VERIFY = 3'd2,
    S_VWAIT  = 3'd3,
    S_RUN    = 3'd4
  } state_t;

  state_t          state, state_nxt;
  logic [63:0]     addr;
  logic [ADDR_W:0] remaining;
  logic [31:0]     checksum;
  logic [63:0]     addr_hold;
  logic [31:0]     wdata_hold;
  logic            done_q;

  logic start_ok;
  logic xfer;
  logic last_xfer;
  logic wen;

`ifdef IMEM_HOST_LOADER_VERIFY_EN
  logic [ADDR_W:0] count_q;
  logic [ADDR_W:0] rd_left;
  logic [31:0]     rb_checksum;
  logic [31:0]     rb_final;
  logic            rd_pending;
  logic            error_q;
  logic            ren;
  logic            verify_fail;

  // The last read's data arrives during VWAIT, so fold it in combinationally.
  assign rb_final = rb_checksum + rdata_ext;
`endif

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) state <= S_IDLE;
    else         state <= state_nxt;
  end

  // --------------------------------------------------------------------------
  // Next-state and strobes
  // --------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    s_ready   = 1'b0;
    wen       = 1'b0;
    start_ok  = 1'b0;
    xfer      = 1'b0;
    last_xfer = 1'b0;
`ifdef IMEM_HOST_LOADER_VERIFY_EN
    ren         = 1'b0;
    verify_fail = 1'b0;
`endif
    case (state)
      S_IDLE: begin
        if (start && !halt) begin
          start_ok  = 1'b1;
          state_nxt = (word_count == '0) ? S_RUN : S_LOAD;
        end
      end
      S_LOAD: begin
        // halt wins over a simultaneous transfer: no write is issued.
        if (halt) begin
          state_nxt = S_IDLE;
        end else begin
          s_ready = 1'b1;
          if (s_valid) begin
            xfer = 1'b1;
            wen  = 1'b1;
            if (remaining == ONE_WORD) begin
              last_xfer = 1'b1;
`ifdef IMEM_HOST_LOADER_VERIFY_EN
              state_nxt = S_VERIFY;
`else
              state_nxt = S_RUN;
`endif
            end
          end
        end
      end
      S_VERIFY: begin
`ifdef IMEM_HOST_LOADER_VERIFY_EN
        if (halt) begin
          state_nxt = S_IDLE;
        end else begin
          ren = 1'b1;
          if (rd_left == ONE_WORD) state_nxt = S_VWAIT;
        end
`else
        state_nxt = S_IDLE;
`endif
      end
      S_VWAIT: begin
`ifdef IMEM_HOST_LOADER_VERIFY_EN
        if (halt) begin
          state_nxt = S_IDLE;
        end else if (rb_final == checksum) begin
          state_nxt = S_RUN;
        end else begin
          verify_fail = 1'b1;
          state_nxt   = S_IDLE;
        end
`else
        state_nxt = S_IDLE;
`endif
      end
      S_RUN: begin
        if (halt) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath: address, counters, checksums, held port values
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      addr       <= 64'h0;
      remaining  <= '0;
      checksum   <= 32'h0;
      addr_hold  <= 64'h0;
      wdata_hold <= 32'h0;
      done_q     <= 1'b0;
`ifdef IMEM_HOST_LOADER_VERIFY_EN
      count_q     <= '0;
      rd_left     <= '0;
      rb_checksum <= 32'h0;
      rd_pending  <= 1'b0;
      error_q     <= 1'b0;
`endif
    end else begin
      if (start_ok) begin
        remaining <= word_count;
        addr      <= BASE_ADDR;
        checksum  <= 32'h0;
      end else if (xfer) begin
        addr      <= addr + WORD_BYTES;
        remaining <= remaining - ONE_WORD;
        checksum  <= checksum + s_data;
      end

      // Port address/data keep the last driven value while enables are low.
      if (wen) begin
        addr_hold  <= addr;
        wdata_hold <= s_data;
      end

      done_q <= (state_nxt == S_RUN) && (state != S_RUN);

`ifdef IMEM_HOST_LOADER_VERIFY_EN
      if (start_ok) begin
        count_q <= word_count;
        error_q <= 1'b0;
      end
      // Rewind for readback; overrides the post-write address increment.
      if (last_xfer) begin
        addr        <= BASE_ADDR;
        rd_left     <= count_q;
        rb_checksum <= 32'h0;
      end
      if (ren) begin
        addr      <= addr + WORD_BYTES;
        rd_left   <= rd_left - ONE_WORD;
        addr_hold <= addr;
      end
      rd_pending <= ren;
      if (rd_pending) rb_checksum <= rb_final;
      if (verify_fail) error_q <= 1'b1;
`endif
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign wen_ext    = wen;
  assign wdata_ext  = wen ? s_data : wdata_hold;
  assign cpu_enable = (state == S_RUN) && !halt;
  assign busy       = (state == S_LOAD) || (state == S_VERIFY) || (state == S_VWAIT);
  assign done       = done_q;

`ifdef IMEM_HOST_LOADER_VERIFY_EN
  assign ren_ext  = ren;
  assign error    = error_q;
  assign addr_ext = (wen || ren) ? addr : addr_hold;
`else
  logic unused_sig;
  assign ren_ext    = 1'b0;
  assign error      = 1'b0;
  assign addr_ext   = wen ? addr : addr_hold;
  assign unused_sig = ^{rdata_ext, checksum};
`endif

endmodule
`default_nettype wire
